// File: rtl/vending_pkg.sv
// Coin codes, coin values and FSM encodings shared by vending_machine and change_dispenser.
package vending_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_20 = 8'd20;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_EJECT  = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  function automatic logic [7:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  coin_value = VAL_5;
      COIN_10: coin_value = VAL_10;
      COIN_20: coin_value = VAL_20;
      default: coin_value = 8'd0;
    endcase
  endfunction
endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters (index 0 = 5, 1 = 10, 2 = 20) with one-hot decrement and refill.
module coin_inventory #(
  parameter int INV_W    = 8,
  parameter int INV_INIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             refill,
  input  logic [2:0]       dec,
  output logic [INV_W-1:0] cnt5,
  output logic [INV_W-1:0] cnt10,
  output logic [INV_W-1:0] cnt20,
  output logic [2:0]       empty
);
  localparam logic [INV_W-1:0] INIT = INV_W'(INV_INIT);

  logic [2:0][INV_W-1:0] cnt;

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    // Guard keeps the counter from wrapping even if a decrement arrives on empty.
    always_ff @(posedge clk) begin
      if (!reset_n || refill)
        cnt[i] <= INIT;
      else if (dec[i] && cnt[i] != '0)
        cnt[i] <= cnt[i] - 1'b1;
    end
    assign empty[i] = (cnt[i] == '0);
  end

  assign cnt5  = cnt[0];
  assign cnt10 = cnt[1];
  assign cnt20 = cnt[2];
endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount as a greedy 20/10/5 coin sequence over a valid/ready ejector handshake,
// bounded by coin inventory; reports done, sticky error and the unpaid shortfall.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int INV_W      = 8,
  parameter int INV_INIT   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       change_in,
  input  logic             change_load,
  input  logic             refill,
  input  logic             eject_ready,
  output logic             eject_valid,
  output logic [1:0]       eject_coin,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [7:0]       shortfall,
  output logic [7:0]       remaining,
  output logic [INV_W-1:0] cnt5,
  output logic [INV_W-1:0] cnt10,
  output logic [INV_W-1:0] cnt20,
  output logic [2:0]       state_out
);
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  logic [2:0] state;
  logic [7:0] gap_cnt;
  logic [1:0] pick;
  logic [2:0] dec;
  logic [2:0] empty;
  logic       accept;
  logic       inv_refill;

  // Largest coin that fits and is in stock.
  always_comb begin
    pick = COIN_NONE;
    if (remaining >= VAL_20 && !empty[2])      pick = COIN_20;
    else if (remaining >= VAL_10 && !empty[1]) pick = COIN_10;
    else if (remaining >= VAL_5 && !empty[0])  pick = COIN_5;
  end

  assign accept     = (state == ST_EJECT) && eject_ready;
  assign dec[0]     = accept && (eject_coin == COIN_5);
  assign dec[1]     = accept && (eject_coin == COIN_10);
  assign dec[2]     = accept && (eject_coin == COIN_20);
  assign inv_refill = (state == ST_IDLE) && refill && !change_load;

  coin_inventory #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_inv (
    .clk     (clk),
    .reset_n (reset_n),
    .refill  (inv_refill),
    .dec     (dec),
    .cnt5    (cnt5),
    .cnt10   (cnt10),
    .cnt20   (cnt20),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      eject_coin <= COIN_NONE;
      remaining  <= 8'd0;
      error      <= 1'b0;
      shortfall  <= 8'd0;
      gap_cnt    <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: if (change_load) begin
          remaining <= change_in;
          error     <= 1'b0;
          shortfall <= 8'd0;
          state     <= (change_in % 8'd5 != 8'd0) ? ST_ERR : ST_SELECT;
        end
        ST_SELECT: begin
          if (remaining == 8'd0)
            state <= ST_DONE;
          else if (pick != COIN_NONE) begin
            eject_coin <= pick;
            state      <= ST_EJECT;
          end else
            state <= ST_ERR;
        end
        ST_EJECT: if (eject_ready) begin
          remaining  <= remaining - coin_value(eject_coin);
          eject_coin <= COIN_NONE;
          gap_cnt    <= 8'd0;
          state      <= (GAP_CYCLES == 0) ? ST_SELECT : ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_SELECT;
          else                     gap_cnt <= gap_cnt + 8'd1;
        end
        ST_DONE: begin
          remaining <= 8'd0;
          state     <= ST_IDLE;
        end
        ST_ERR: begin
          shortfall <= remaining;
          error     <= 1'b1;
          remaining <= 8'd0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign eject_valid = (state == ST_EJECT);
  assign done        = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);
  assign state_out   = state;
endmodule
